// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - merges mem and ALU writebacks into one in-order register-file write port
module regfile_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 3,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          mem_req,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    input  logic          alu_req,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    output logic          in_ready,
    output logic          stall,
    output logic          reg_write,
    output logic [AW-1:0] write_addr,
    output logic [DW-1:0] write_data,
    output logic [7:0]    pending_mask
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] r_addr_q [DEPTH];
    logic [DW-1:0] r_data_q [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          w_enq_mem;
    logic          w_enq_alu;
    logic          w_deq;
    logic [1:0]    w_n_enq;
    logic [CW-1:0] w_count_next;
    logic [PW-1:0] w_wr_alu_ptr;
    logic [PW-1:0] w_wr_next;
    logic [PW-1:0] w_rd_next;
    logic [AW-1:0] w_addr_nxt [DEPTH];
    logic [7:0]    w_mask_next;

    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
        return PW'((int'(p) + n) % DEPTH);
    endfunction

    // Both ports are gated by the same registered ready, so acceptance never depends on the other port.
    assign w_enq_mem    = mem_req & in_ready;
    assign w_enq_alu    = alu_req & in_ready;
    assign w_deq        = (r_count != '0);
    assign w_n_enq      = {1'b0, w_enq_mem} + {1'b0, w_enq_alu};
    assign w_count_next = r_count + CW'(w_n_enq) - CW'(w_deq);
    assign w_wr_alu_ptr = ptr_add(r_wr_ptr, int'(w_enq_mem));
    assign w_wr_next    = ptr_add(r_wr_ptr, int'(w_n_enq));
    assign w_rd_next    = ptr_add(r_rd_ptr, int'(w_deq));
    assign stall        = ~in_ready;

    // Queue addresses as they will look after this edge, used to build the next pending mask.
    always_comb begin
        w_addr_nxt = r_addr_q;
        if (w_enq_mem) w_addr_nxt[r_wr_ptr] = mem_addr;
        if (w_enq_alu) w_addr_nxt[w_wr_alu_ptr] = alu_addr;
    end

    always_comb begin
        w_mask_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(w_count_next)) begin
                for (int j = 0; j < 8; j++) begin
                    if (int'(w_addr_nxt[ptr_add(w_rd_next, i)]) == j) w_mask_next[j] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr_q[i] <= '0;
                r_data_q[i] <= '0;
            end
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            reg_write    <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
            pending_mask <= '0;
            in_ready     <= 1'b1;
        end else if (flush) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            reg_write    <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
            pending_mask <= '0;
            in_ready     <= 1'b1;
        end else begin
            if (w_enq_mem) begin
                r_addr_q[r_wr_ptr] <= mem_addr;
                r_data_q[r_wr_ptr] <= mem_data;
            end
            if (w_enq_alu) begin
                r_addr_q[w_wr_alu_ptr] <= alu_addr;
                r_data_q[w_wr_alu_ptr] <= alu_data;
            end
            if (w_deq) begin
                reg_write  <= 1'b1;
                write_addr <= r_addr_q[r_rd_ptr];
                write_data <= r_data_q[r_rd_ptr];
            end else begin
                reg_write  <= 1'b0;
            end
            r_rd_ptr     <= w_rd_next;
            r_wr_ptr     <= w_wr_next;
            r_count      <= w_count_next;
            pending_mask <= w_mask_next;
            in_ready     <= (w_count_next <= CW'(DEPTH - 2));
        end
    end

endmodule
